// File: rtl/if_prefetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : if_prefetch_queue                                            |
// | Brief   : Instruction fetch stage. Issues pipelined imem requests      |
// |           (up to MAX_OUTS in flight), collects responses into an       |
// |           in-order QDEPTH-entry prefetch queue that drains to ID, and  |
// |           handles predictor, JAL-predecode and EX-flush redirects.     |
// | Rev     : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module if_prefetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned MAX_OUTS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] out_npc
);

  localparam int unsigned     c_QW        = $clog2(QDEPTH);
  localparam int unsigned     c_CW        = c_QW + 1;
  localparam int unsigned     c_SW        = c_CW + 1;
  localparam int unsigned     c_PW        = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
  localparam logic [c_CW-1:0] c_QDEPTH_C  = c_CW'(QDEPTH);
  localparam logic [c_SW-1:0] c_QDEPTH_S  = c_SW'(QDEPTH);
  localparam logic [c_CW-1:0] c_MAX_OUTS  = c_CW'(MAX_OUTS);
  localparam logic [c_PW-1:0] c_PEND_LAST = c_PW'(MAX_OUTS - 1);
  localparam logic [6:0]      c_OP_JAL    = 7'b1101111;

  typedef enum logic [0:0] {
    ST_START = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [c_QW-1:0] head_q, head_d;
  logic [c_QW-1:0] tail_q, tail_d;
  logic [c_CW-1:0] count_q, count_d;
  logic [c_CW-1:0] outs_q, outs_d;
  logic [c_CW-1:0] drop_q, drop_d;
  logic [c_PW-1:0] pend_wr_q, pend_wr_d;
  logic [c_PW-1:0] pend_rd_q, pend_rd_d;

  // Prefetch queue and pending-PC storage (datapath only, validity held by pointers)
  logic [31:0] q_pc_q     [QDEPTH];
  logic [31:0] q_inst_q   [QDEPTH];
  logic [31:0] q_npc_q    [QDEPTH];
  logic [31:0] pend_pc_q  [MAX_OUTS];
  logic [31:0] pend_npc_q [MAX_OUTS];

  logic        req_credit;
  logic        req_fire;
  logic [31:0] req_next_pc;
  logic [31:0] pend_head_pc;
  logic [31:0] pend_head_npc;
  logic [31:0] jal_imm;
  logic [31:0] jal_tgt;
  logic        rsp_take;
  logic        jal_redir;
  logic        enq;
  logic        deq;
  logic        pend_push;
  logic [31:0] enq_npc;

  function automatic logic [c_PW-1:0] pend_inc(input logic [c_PW-1:0] p);
    return (p == c_PEND_LAST) ? '0 : p + 1'b1;
  endfunction

  // Request side: credits cover both in-flight requests and queued entries
  always_comb begin
    req_credit     = ({1'b0, outs_q} + {1'b0, count_q}) < c_QDEPTH_S;
    imem_req_valid = (state_q == ST_RUN) && req_credit && (outs_q < c_MAX_OUTS) && !flush;
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    req_next_pc    = pred_taken ? pred_target : fetch_pc_q + 32'd4;
  end

  // Response side: JAL predecode against the PC/npc recorded at request time
  always_comb begin
    pend_head_pc  = pend_pc_q[pend_rd_q];
    pend_head_npc = pend_npc_q[pend_rd_q];
    jal_imm       = {{11{imem_rsp_data[31]}}, imem_rsp_data[31], imem_rsp_data[19:12],
                     imem_rsp_data[20], imem_rsp_data[30:21], 1'b0};
    jal_tgt       = pend_head_pc + jal_imm;
    rsp_take      = imem_rsp_valid && (drop_q == '0);
    jal_redir     = rsp_take && (imem_rsp_data[6:0] == c_OP_JAL) && (jal_tgt != pend_head_npc);
  end

  // FSM next state: a single idle cycle after reset before fetching starts
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_START;
    endcase
  end

  // Pointer/counter next state; flush overrides JAL redirect, which overrides issue
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    drop_d     = drop_q;
    pend_wr_d  = pend_wr_q;
    pend_rd_d  = pend_rd_q;
    enq        = 1'b0;
    pend_push  = 1'b0;
    enq_npc    = pend_head_npc;
    deq        = out_valid && out_ready;
    outs_d     = outs_q + c_CW'(req_fire) - c_CW'(imem_rsp_valid);

    if (req_fire) begin
      fetch_pc_d = req_next_pc;
      pend_push  = 1'b1;
      pend_wr_d  = pend_inc(pend_wr_q);
    end

    if (imem_rsp_valid) begin
      if (drop_q != '0) begin
        // Stale response from before a redirect: consume it without a pending pop
        drop_d = drop_q - 1'b1;
      end else begin
        enq       = 1'b1;
        pend_rd_d = pend_inc(pend_rd_q);
        if (jal_redir) begin
          // Everything still in flight (including a request firing now) is stale
          enq_npc    = jal_tgt;
          fetch_pc_d = jal_tgt;
          drop_d     = outs_d;
          pend_push  = 1'b0;
          pend_wr_d  = '0;
          pend_rd_d  = '0;
        end
      end
    end

    if (flush) begin
      enq        = 1'b0;
      deq        = 1'b0;
      pend_push  = 1'b0;
      pend_wr_d  = '0;
      pend_rd_d  = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = flush_pc;
      drop_d     = outs_d;
    end

    if (enq) begin
      tail_d = tail_q + 1'b1;
    end
    if (deq) begin
      head_d = head_q + 1'b1;
    end
    if (!flush) begin
      count_d = count_q + c_CW'(enq) - c_CW'(deq);
    end else begin
      count_d = '0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_START;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      outs_q     <= '0;
      drop_q     <= '0;
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      outs_q     <= outs_d;
      drop_q     <= drop_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
    end
  end

  // Storage writes: queue entry on enqueue, pending PC pair on request fire
  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc_q[tail_q]   <= pend_head_pc;
      q_inst_q[tail_q] <= imem_rsp_data;
      q_npc_q[tail_q]  <= enq_npc;
    end
    if (pend_push) begin
      pend_pc_q[pend_wr_q]  <= fetch_pc_q;
      pend_npc_q[pend_wr_q] <= req_next_pc;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? q_pc_q[head_q]   : '0;
  assign out_inst  = out_valid ? q_inst_q[head_q] : '0;
  assign out_npc   = out_valid ? q_npc_q[head_q]  : '0;

  // Illegal traffic: a response with nothing in flight, or an enqueue into a full queue
  a_rsp_has_outstanding: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (outs_q != '0));
  a_queue_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (enq && !deq) |-> (count_q != c_QDEPTH_C));

endmodule
`default_nettype wire
